icb_protocol_monitor: RTL and testbench

- Synthesizable, parametrised ICB protocol checker; passive tap on any ICB master/slave link.
- Replaces simulation-only assertions with registered checks, outstanding-transaction tracking, handshake timeouts, sticky error status and traffic counters.
- Usable in silicon debug as well as under the bench.

---
 rtl/icb_mon_pkg.sv | 30 +++
 rtl/icb_mon_type_fifo.sv | 69 ++++++
 rtl/icb_protocol_monitor.sv | 191 +++++++++++++++++++
 tb/tb_icb_protocol_monitor.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/icb_mon_pkg.sv
// Shared definitions for the ICB protocol monitor: error bit indices and the
// error vector type.
package icb_mon_pkg;

  localparam int unsigned ERR_ADDR_CHG    = 0;
  localparam int unsigned ERR_READ_CHG    = 1;
  localparam int unsigned ERR_WDATA_CHG   = 2;
  localparam int unsigned ERR_WMASK_CHG   = 3;
  localparam int unsigned ERR_CVALID_DROP = 4;
  localparam int unsigned ERR_RVALID_DROP = 5;
  localparam int unsigned ERR_RSP_CHG     = 6;
  localparam int unsigned ERR_RSP_ORPHAN  = 7;
  localparam int unsigned ERR_OVERFLOW    = 8;
  localparam int unsigned ERR_CMD_TMO     = 9;
  localparam int unsigned ERR_RSP_TMO     = 10;
  localparam int unsigned NUM_ERR         = 11;

  typedef logic [NUM_ERR-1:0] err_vec_t;

  // Lowest set index wins when several errors appear together.
  function automatic logic [3:0] lowest_err_idx(input err_vec_t v);
    logic [3:0] idx;
    idx = '0;
    for (int i = NUM_ERR - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/icb_mon_type_fifo.sv
// 1-bit transaction-type FIFO with occupancy count. Empty push+pop bypasses
// storage; push into a full FIFO without a pop is dropped.
module icb_mon_type_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     din_i,
  output logic                     pop_vld_o,
  output logic                     pop_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty, full, bypass, do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign bypass  = push_i & pop_i & empty;
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & ~bypass & (~full | do_pop);

  assign pop_vld_o  = do_pop | bypass;
  assign pop_data_o = empty ? din_i : mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/icb_protocol_monitor.sv
// Passive ICB link checker: payload stability, handshake drops, orphan/overflow,
// timeouts, sticky status with first-error capture, and traffic counters.
module icb_protocol_monitor
  import icb_mon_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned TIMEOUT   = 256,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      icb_cmd_valid,
  input  logic                      icb_cmd_ready,
  input  logic                      icb_cmd_read,
  input  logic [ADDR_W-1:0]         icb_cmd_addr,
  input  logic [DATA_W-1:0]         icb_cmd_wdata,
  input  logic [DATA_W/8-1:0]       icb_cmd_wmask,
  input  logic                      icb_rsp_valid,
  input  logic                      icb_rsp_ready,
  input  logic                      icb_rsp_err,
  input  logic [DATA_W-1:0]         icb_rsp_rdata,
  input  logic                      mon_en,
  input  logic                      err_clr,
  output logic [NUM_ERR-1:0]        err_sticky,
  output logic                      err_pulse,
  output logic                      first_err_vld,
  output logic [3:0]                first_err_code,
  output logic [$clog2(MAX_OUTST):0] outstanding,
  output logic [CNT_W-1:0]          rd_cnt,
  output logic [CNT_W-1:0]          wr_cnt,
  output logic [CNT_W-1:0]          rsp_err_cnt
);

  localparam int unsigned MW = DATA_W / 8;
  localparam int unsigned OW = $clog2(MAX_OUTST) + 1;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic              cmd_hs, rsp_hs;
  logic [ADDR_W-1:0] addr_q;
  logic              read_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [MW-1:0]     wmask_q;
  logic              rerr_q, stall_c_q, stall_r_q;

  logic              pop_vld, pop_read;
  logic [OW-1:0]     outst;

  logic [TW-1:0]     cmd_tmo_q, cmd_tmo_d, rsp_tmo_q, rsp_tmo_d;
  logic              cmd_tmo_hit, rsp_tmo_hit, tmo_on, cmd_wait, rsp_wait;

  err_vec_t          raw_err, new_err, sticky_q, sticky_d;
  logic              pulse_q, first_vld_q, first_vld_d;
  logic [3:0]        first_code_q, first_code_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, rerr_cnt_q, rerr_cnt_d;

  assign cmd_hs = icb_cmd_valid & icb_cmd_ready;
  assign rsp_hs = icb_rsp_valid & icb_rsp_ready;

  icb_mon_type_fifo #(.DEPTH(MAX_OUTST)) u_type_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (cmd_hs),
    .pop_i     (rsp_hs),
    .din_i     (icb_cmd_read),
    .pop_vld_o (pop_vld),
    .pop_data_o(pop_read),
    .count_o   (outst)
  );

  assign tmo_on   = mon_en && (TIMEOUT != 0);
  assign cmd_wait = icb_cmd_valid & ~icb_cmd_ready;
  assign rsp_wait = (outst != '0) & ~rsp_hs;

  // Wait counters saturate at TIMEOUT so each stall raises its flag only once.
  always_comb begin
    cmd_tmo_d   = '0;
    rsp_tmo_d   = '0;
    cmd_tmo_hit = 1'b0;
    rsp_tmo_hit = 1'b0;
    if (tmo_on && cmd_wait) begin
      cmd_tmo_d = cmd_tmo_q;
      if (cmd_tmo_q != TMO_MAX) begin
        cmd_tmo_d   = cmd_tmo_q + TW'(1);
        cmd_tmo_hit = (cmd_tmo_q == TMO_LAST);
      end
    end
    if (tmo_on && rsp_wait) begin
      rsp_tmo_d = rsp_tmo_q;
      if (rsp_tmo_q != TMO_MAX) begin
        rsp_tmo_d   = rsp_tmo_q + TW'(1);
        rsp_tmo_hit = (rsp_tmo_q == TMO_LAST);
      end
    end
  end

  always_comb begin
    raw_err                  = '0;
    raw_err[ERR_ADDR_CHG]    = stall_c_q & (icb_cmd_addr != addr_q);
    raw_err[ERR_READ_CHG]    = stall_c_q & (icb_cmd_read != read_q);
    raw_err[ERR_WDATA_CHG]   = stall_c_q & ~icb_cmd_read & (icb_cmd_wdata != wdata_q);
    raw_err[ERR_WMASK_CHG]   = stall_c_q & ~icb_cmd_read & (icb_cmd_wmask != wmask_q);
    raw_err[ERR_CVALID_DROP] = stall_c_q & ~icb_cmd_valid;
    raw_err[ERR_RVALID_DROP] = stall_r_q & ~icb_rsp_valid;
    raw_err[ERR_RSP_CHG]     = stall_r_q & ((icb_rsp_err != rerr_q) |
                                            (pop_read & (icb_rsp_rdata != rdata_q)));
    raw_err[ERR_RSP_ORPHAN]  = rsp_hs & (outst == '0) & ~cmd_hs;
    raw_err[ERR_OVERFLOW]    = cmd_hs & (outst == OW'(MAX_OUTST)) & ~rsp_hs;
    raw_err[ERR_CMD_TMO]     = cmd_tmo_hit;
    raw_err[ERR_RSP_TMO]     = rsp_tmo_hit;
    new_err                  = mon_en ? raw_err : '0;
  end

  // Clear is applied first so an error arriving with err_clr survives it.
  always_comb begin
    sticky_d     = (err_clr ? '0 : sticky_q) | new_err;
    first_vld_d  = err_clr ? 1'b0 : first_vld_q;
    first_code_d = err_clr ? 4'd0 : first_code_q;
    if (!first_vld_d && (new_err != '0)) begin
      first_vld_d  = 1'b1;
      first_code_d = lowest_err_idx(new_err);
    end
  end

  always_comb begin
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    rerr_cnt_d = rerr_cnt_q;
    if (pop_vld) begin
      if (pop_read) begin
        if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_W'(1);
      end else begin
        if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
      if (icb_rsp_err && (rerr_cnt_q != '1)) rerr_cnt_d = rerr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      read_q       <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rdata_q      <= '0;
      rerr_q       <= 1'b0;
      stall_c_q    <= 1'b0;
      stall_r_q    <= 1'b0;
      cmd_tmo_q    <= '0;
      rsp_tmo_q    <= '0;
      sticky_q     <= '0;
      pulse_q      <= 1'b0;
      first_vld_q  <= 1'b0;
      first_code_q <= '0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      rerr_cnt_q   <= '0;
    end else begin
      addr_q       <= icb_cmd_addr;
      read_q       <= icb_cmd_read;
      wdata_q      <= icb_cmd_wdata;
      wmask_q      <= icb_cmd_wmask;
      rdata_q      <= icb_rsp_rdata;
      rerr_q       <= icb_rsp_err;
      stall_c_q    <= icb_cmd_valid & ~icb_cmd_ready;
      stall_r_q    <= icb_rsp_valid & ~icb_rsp_ready;
      cmd_tmo_q    <= cmd_tmo_d;
      rsp_tmo_q    <= rsp_tmo_d;
      sticky_q     <= sticky_d;
      pulse_q      <= |new_err;
      first_vld_q  <= first_vld_d;
      first_code_q <= first_code_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      rerr_cnt_q   <= rerr_cnt_d;
    end
  end

  assign err_sticky     = sticky_q;
  assign err_pulse      = pulse_q;
  assign first_err_vld  = first_vld_q;
  assign first_err_code = first_code_q;
  assign outstanding    = outst;
  assign rd_cnt         = rd_cnt_q;
  assign wr_cnt         = wr_cnt_q;
  assign rsp_err_cnt    = rerr_cnt_q;

endmodule

// File: tb/tb_icb_protocol_monitor.sv
// Directed bench for icb_protocol_monitor with MAX_OUTST=4, TIMEOUT=8.
module tb_icb_protocol_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_read;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mon_en, err_clr;
  logic [10:0] err_sticky;
  logic        err_pulse, first_err_vld;
  logic [3:0]  first_err_code;
  logic [2:0]  outstanding;
  logic [15:0] rd_cnt, wr_cnt, rsp_err_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned pulses;

  icb_protocol_monitor #(
    .ADDR_W(32), .DATA_W(32), .MAX_OUTST(4), .TIMEOUT(8), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(cmd_valid), .icb_cmd_ready(cmd_ready), .icb_cmd_read(cmd_read),
    .icb_cmd_addr(cmd_addr), .icb_cmd_wdata(cmd_wdata), .icb_cmd_wmask(cmd_wmask),
    .icb_rsp_valid(rsp_valid), .icb_rsp_ready(rsp_ready), .icb_rsp_err(rsp_err),
    .icb_rsp_rdata(rsp_rdata), .mon_en(mon_en), .err_clr(err_clr),
    .err_sticky(err_sticky), .err_pulse(err_pulse), .first_err_vld(first_err_vld),
    .first_err_code(first_err_code), .outstanding(outstanding),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .rsp_err_cnt(rsp_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cmd_valid = 1'b0; cmd_ready = 1'b0;
    rsp_valid = 1'b0; rsp_ready = 1'b0; rsp_err = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic clear_status();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mon_en = 1'b1; cmd_read = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wmask = '0; rsp_rdata = '0;
    idle();
    repeat (3) tick();
    check("rst_sticky", 32'(err_sticky), 0);
    check("rst_outst", 32'(outstanding), 0);
    check("rst_first_vld", 32'(first_err_vld), 0);
    check("rst_rd_cnt", 32'(rd_cnt), 0);
    rst_n = 1'b1;
    tick();

    // Clean write with 3-cycle command stall and delayed response
    cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 32'h10;
    cmd_wdata = 32'hAA; cmd_wmask = 4'hF;
    repeat (3) tick();
    cmd_ready = 1'b1;
    tick();
    check("wr_outst_1", 32'(outstanding), 1);
    idle();
    repeat (2) tick();
    rsp_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    idle();
    tick();
    check("wr_outst_0", 32'(outstanding), 0);
    check("wr_cnt_1", 32'(wr_cnt), 1);
    check("wr_sticky", 32'(err_sticky), 0);

    // Address changes during stall
    cmd_valid = 1'b1; cmd_addr = 32'h10;
    tick();
    cmd_addr = 32'h14;
    tick();
    check("addr_sticky", 32'(err_sticky), 32'h1);
    check("addr_pulse", 32'(err_pulse), 1);
    check("addr_first_vld", 32'(first_err_vld), 1);
    check("addr_first_code", 32'(first_err_code), 0);
    tick();
    check("addr_pulse_off", 32'(err_pulse), 0);
    cmd_ready = 1'b1;
    tick();
    idle();
    rsp_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    idle();
    clear_status();
    check("clr_sticky", 32'(err_sticky), 0);
    check("clr_first_vld", 32'(first_err_vld), 0);
    check("wr_cnt_2", 32'(wr_cnt), 2);

    // Five back-to-back reads overflow a 4-deep tracker
    cmd_valid = 1'b1; cmd_ready = 1'b1; cmd_read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmd_addr = 32'h100 + 32'(i * 4);
      tick();
    end
    check("ovf_sticky", 32'(err_sticky), 32'h100);
    check("ovf_outst", 32'(outstanding), 4);
    check("ovf_first_code", 32'(first_err_code), 8);
    idle();
    rsp_valid = 1'b1; rsp_ready = 1'b1; rsp_rdata = 32'h1234;
    repeat (4) tick();
    idle();
    tick();
    check("ovf_rd_cnt", 32'(rd_cnt), 4);
    check("ovf_outst_0", 32'(outstanding), 0);
    check("ovf_no_orphan", 32'(err_sticky), 32'h100);
    clear_status();

    // Command timeout, then err_clr coinciding with a response change
    pulses = 0;
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h200;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (err_pulse) pulses++;
      if (i == 6) check("tmo_not_yet", 32'(err_sticky), 0);
      if (i == 7) check("tmo_sticky", 32'(err_sticky), 32'h200);
    end
    check("tmo_pulse_once", pulses, 1);
    check("tmo_first_code", 32'(first_err_code), 9);
    cmd_ready = 1'b1;
    tick();
    idle();
    rsp_valid = 1'b1; rsp_rdata = 32'h55;
    tick();
    rsp_rdata = 32'h66; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_vs_new_sticky", 32'(err_sticky), 32'h40);
    check("clr_vs_new_code", 32'(first_err_code), 6);
    check("clr_vs_new_vld", 32'(first_err_vld), 1);
    rsp_ready = 1'b1;
    tick();
    idle();
    tick();
    check("tmo_rd_cnt", 32'(rd_cnt), 5);
    clear_status();

    // Orphan response, then legal same-cycle bypass with error response
    rsp_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    idle();
    check("orphan_sticky", 32'(err_sticky), 32'h80);
    check("orphan_code", 32'(first_err_code), 7);
    check("orphan_rd_cnt", 32'(rd_cnt), 5);
    check("orphan_wr_cnt", 32'(wr_cnt), 2);
    clear_status();
    cmd_valid = 1'b1; cmd_ready = 1'b1; cmd_read = 1'b1;
    rsp_valid = 1'b1; rsp_ready = 1'b1; rsp_err = 1'b1;
    tick();
    idle();
    tick();
    check("bypass_sticky", 32'(err_sticky), 0);
    check("bypass_rd_cnt", 32'(rd_cnt), 6);
    check("bypass_err_cnt", 32'(rsp_err_cnt), 1);
    check("bypass_outst", 32'(outstanding), 0);

    // Monitoring disabled: response valid drops mid-stall without a flag
    cmd_valid = 1'b1; cmd_ready = 1'b1; cmd_read = 1'b0;
    tick();
    idle();
    mon_en = 1'b0;
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    tick();
    tick();
    check("dis_sticky", 32'(err_sticky), 0);
    check("dis_pulse", 32'(err_pulse), 0);
    check("dis_outst", 32'(outstanding), 1);
    mon_en = 1'b1;

    // Asynchronous reset in the middle of a burst
    cmd_valid = 1'b1; cmd_ready = 1'b1;
    repeat (2) tick();
    check("burst_outst", 32'(outstanding), 3);
    rst_n = 1'b0;
    #1;
    check("arst_outst", 32'(outstanding), 0);
    check("arst_rd_cnt", 32'(rd_cnt), 0);
    check("arst_wr_cnt", 32'(wr_cnt), 0);
    check("arst_err_cnt", 32'(rsp_err_cnt), 0);
    check("arst_sticky", 32'(err_sticky), 0);
    idle();
    tick();
    rst_n = 1'b1;
    tick();
    rsp_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    idle();
    check("post_rst_orphan", 32'(err_sticky), 32'h80);
    check("post_rst_wr_cnt", 32'(wr_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
